// File: rtl/fifo_dc_wr_packer.sv
// Write-side packer for the dual-clock FIFO: gathers RATIO narrow beats,
// little-endian, into one wide word and issues it as a FIFO write when not full.
module fifo_dc_wr_packer #(
  parameter int unsigned          IN_WIDTH  = 8,
  parameter int unsigned          RATIO     = 4,
  parameter logic [IN_WIDTH-1:0]  PAD_VALUE = '0
) (
  input  logic                         wrclk,
  input  logic                         aclr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_last,
  input  logic                         fifo_wrfull,
  output logic                         fifo_wrreq,
  output logic [IN_WIDTH*RATIO-1:0]    fifo_data,
  output logic [$clog2(RATIO)-1:0]     lane_count,
  output logic [15:0]                  words_written
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned LW        = $clog2(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [LW-1:0]        lane_q,   lane_d;
  logic [OUT_WIDTH-1:0] acc_q,    acc_d;
  logic [OUT_WIDTH-1:0] obuf_q,   obuf_d;
  logic                 ovalid_q, ovalid_d;
  logic [15:0]          words_q,  words_d;

  logic                 accept;
  logic                 complete;
  logic [OUT_WIDTH-1:0] acc_merge;
  logic [OUT_WIDTH-1:0] word_padded;

  assign fifo_wrreq    = ovalid_q & ~fifo_wrfull;
  assign in_ready      = ~ovalid_q | ~fifo_wrfull;
  assign fifo_data     = obuf_q;
  assign lane_count    = lane_q;
  assign words_written = words_q;

  always_comb begin
    accept      = in_valid & in_ready;
    complete    = accept & (in_last | (lane_q == LAST_LANE));
    acc_merge   = acc_q;
    word_padded = acc_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i == 32'(lane_q)) begin
        acc_merge[i*IN_WIDTH +: IN_WIDTH]   = in_data;
        word_padded[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end else if (i > 32'(lane_q)) begin
        word_padded[i*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
      end
    end

    lane_d   = lane_q;
    acc_d    = acc_q;
    obuf_d   = obuf_q;
    ovalid_d = ovalid_q;
    words_d  = words_q;

    if (fifo_wrreq) begin
      ovalid_d = 1'b0;
      words_d  = words_q + 16'd1;
    end

    if (accept) begin
      if (complete) begin
        // a completion on the same edge as a drain keeps ovalid set with the new word
        obuf_d   = word_padded;
        ovalid_d = 1'b1;
        lane_d   = '0;
        acc_d    = '0;
      end else begin
        acc_d  = acc_merge;
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge wrclk or posedge aclr) begin
    if (aclr) begin
      lane_q   <= '0;
      acc_q    <= '0;
      obuf_q   <= '0;
      ovalid_q <= 1'b0;
      words_q  <= '0;
    end else begin
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      obuf_q   <= obuf_d;
      ovalid_q <= ovalid_d;
      words_q  <= words_d;
    end
  end

endmodule
